// File: rtl/perceptron_pkg.sv
// Shared types and widths for the perceptron sequencer slice.
package perceptron_pkg;

    localparam int ADDR_W = 9;
    localparam int WORD_W = 32;
    localparam int WCNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        EVAL,
        WAIT,
        WRITE,
        DONE
    } seq_state_e;

endpackage

// File: rtl/perceptron_seq_counter.sv
// Loadable up-counter with a terminal-value flag; load takes priority over count.
module perceptron_seq_counter
    import perceptron_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_val_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == term_val_i);

endmodule

// File: rtl/perceptron_sequencer.sv
// Sequences BRAM operand reads, a perceptron evaluate strobe and result capture/write-back.
// Optional result write-back to BRAM is enabled by defining PERCEPTRON_SEQ_WRITEBACK_EN.
module perceptron_sequencer
    import perceptron_pkg::*;
#(
    parameter int                N          = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = 9'd0,
    parameter int                EVAL_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [WORD_W-1:0] bram_wdata,
    output logic [ADDR_W-1:0] data_addr,
    output logic              perc_enable,
    input  logic [15:0]       perc_y,
    input  logic              perc_fire,
    input  logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       result,
    output logic              result_fire
);

    localparam int                IW         = $clog2(N + 1);
    // Parking address: one past the operand block, so no controller input register matches.
    localparam logic [ADDR_W-1:0] PARK_ADDR  = ADDR_W'(int'(START_ADDR) + N);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(N - 1);
    localparam logic [WCNT_W-1:0] DRAIN_LAST = WCNT_W'(2);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(EVAL_WAIT - 1);

    seq_state_e state_q, state_d;

    logic [IW-1:0]     idx;
    logic              idx_load, idx_en, idx_term;
    logic [WCNT_W-1:0] wcnt_count_unused;
    logic [WCNT_W-1:0] wcnt_term_val;
    logic              wcnt_load, wcnt_en, wcnt_term;
    logic              capture;

    logic [15:0]       result_q;
    logic              result_fire_q;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;

    perceptron_seq_counter #(.W(IW)) u_idx_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (idx_load),
        .load_val_i ('0),
        .en_i       (idx_en),
        .term_val_i (IDX_LAST),
        .count_o    (idx),
        .term_o     (idx_term)
    );

    // One counter times both the fixed drain window and the evaluation wait.
    assign wcnt_term_val = (state_q == WAIT) ? WAIT_LAST : DRAIN_LAST;

    perceptron_seq_counter #(.W(WCNT_W)) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (wcnt_load),
        .load_val_i ('0),
        .en_i       (wcnt_en),
        .term_val_i (wcnt_term_val),
        .count_o    (wcnt_count_unused),
        .term_o     (wcnt_term)
    );

    always_comb begin
        state_d     = state_q;
        idx_load    = 1'b0;
        idx_en      = 1'b0;
        wcnt_load   = 1'b0;
        wcnt_en     = 1'b0;
        capture     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        bram_en     = 1'b0;
        bram_we     = 1'b0;
        bram_addr   = START_ADDR;
        bram_wdata  = '0;
        perc_enable = 1'b0;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                idx_load  = 1'b1;
                wcnt_load = 1'b1;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                bram_en   = 1'b1;
                bram_addr = START_ADDR + ADDR_W'(idx);
                if (idx_term) begin
                    idx_load = 1'b1;
                    state_d  = DRAIN;
                end else begin
                    idx_en = 1'b1;
                end
            end
            DRAIN: begin
                if (wcnt_term) begin
                    wcnt_load = 1'b1;
                    state_d   = EVAL;
                end else begin
                    wcnt_en = 1'b1;
                end
            end
            EVAL: begin
                perc_enable = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (wcnt_term) begin
                    wcnt_load = 1'b1;
                    capture   = 1'b1;
`ifdef PERCEPTRON_SEQ_WRITEBACK_EN
                    state_d   = WRITE;
`else
                    state_d   = DONE;
`endif
                end else begin
                    wcnt_en = 1'b1;
                end
            end
`ifdef PERCEPTRON_SEQ_WRITEBACK_EN
            WRITE: begin
                bram_en    = 1'b1;
                bram_we    = 1'b1;
                bram_addr  = out_addr;
                bram_wdata = {15'b0, result_fire_q, result_q};
                state_d    = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef PERCEPTRON_SEQ_WRITEBACK_EN
    logic out_addr_unused;
    assign out_addr_unused = ^out_addr;
`endif

    // Tag follows the BRAM's one-cycle read latency; parked otherwise.
    assign data_addr_d = (state_q == LOAD) ? bram_addr : PARK_ADDR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            data_addr_q   <= PARK_ADDR;
            result_q      <= '0;
            result_fire_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_addr_q <= data_addr_d;
            if (capture) begin
                result_q      <= perc_y;
                result_fire_q <= perc_fire;
            end
        end
    end

    assign data_addr   = data_addr_q;
    assign result      = result_q;
    assign result_fire = result_fire_q;

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Scoreboard bench for perceptron_sequencer: per-cycle expected entries queued at run start.
module tb_perceptron_sequencer;

    localparam int        N    = 8;
    localparam int        EW   = 4;
    localparam logic [8:0] SA  = 9'd0;
`ifdef PERCEPTRON_SEQ_WRITEBACK_EN
    localparam int        WB   = 1;
`else
    localparam int        WB   = 0;
`endif
    localparam logic [8:0] PARK   = SA + 9'(N);
    localparam int         CAP_C  = N + EW + 4;
    localparam int         WR_C   = N + EW + 5;
    localparam int         DONE_C = N + EW + 5 + WB;

    logic        clk, rst_n, start;
    logic        busy, done, bram_en, bram_we, perc_enable, perc_fire, result_fire;
    logic [8:0]  bram_addr, data_addr, out_addr;
    logic [31:0] bram_wdata;
    logic [15:0] perc_y, result;

    perceptron_sequencer #(.N(N), .START_ADDR(SA), .EVAL_WAIT(EW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .data_addr   (data_addr),
        .perc_enable (perc_enable),
        .perc_y      (perc_y),
        .perc_fire   (perc_fire),
        .out_addr    (out_addr),
        .result      (result),
        .result_fire (result_fire)
    );

    typedef struct {
        logic [15:0] py;
        logic        pf;
        logic [8:0]  oa;
        logic        busy;
        logic        done;
        logic        en;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [8:0]  daddr;
        logic        pen;
        logic [15:0] res;
        logic        rf;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] m_res;
    logic        m_fire;
    logic [15:0] nx_base;
    logic        nx_vary;
    logic [8:0]  nx_oa;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        assert (int'(SA) + N <= 511) else $fatal(1, "FAIL addr_range START_ADDR+N=%0d limit=511", int'(SA) + N);
    end

    function automatic ent_t idle_ent();
        ent_t e;
        e.py = 16'h0; e.pf = 1'b0; e.oa = 9'h0;
        e.busy = 1'b0; e.done = 1'b0; e.en = 1'b0; e.we = 1'b0;
        e.addr = SA; e.wdata = 32'h0; e.daddr = PARK; e.pen = 1'b0;
        e.res = m_res; e.rf = m_fire;
        return e;
    endfunction

    // Expected cycle-by-cycle behaviour of one run, cycle 0 being the IDLE cycle sampling start.
    task automatic push_run();
        ent_t        e;
        logic [15:0] new_r;
        logic        new_f;
        new_r = nx_vary ? nx_base + 16'(CAP_C) : nx_base;
        new_f = nx_vary ? ((CAP_C % 2) == 1) : 1'b1;
        for (int c = 0; c <= DONE_C; c++) begin
            e.py    = nx_vary ? nx_base + 16'(c) : nx_base;
            e.pf    = nx_vary ? ((c % 2) == 1) : 1'b1;
            e.oa    = nx_oa;
            e.busy  = (c >= 1);
            e.done  = (c == DONE_C);
            e.we    = (WB == 1) && (c == WR_C);
            e.en    = (c >= 1 && c <= N) || e.we;
            e.addr  = (c >= 1 && c <= N) ? SA + 9'(c - 1) : (e.we ? nx_oa : SA);
            e.wdata = e.we ? {15'b0, new_f, new_r} : 32'h0;
            e.daddr = (c >= 2 && c <= N + 1) ? SA + 9'(c - 2) : PARK;
            e.pen   = (c == N + 4);
            e.res   = (c > CAP_C) ? new_r : m_res;
            e.rf    = (c > CAP_C) ? new_f : m_fire;
            q.push_back(e);
        end
        m_res  = new_r;
        m_fire = new_f;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cmp_ent(input ent_t e);
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("bram_en", 32'(bram_en), 32'(e.en));
        chk("bram_we", 32'(bram_we), 32'(e.we));
        chk("bram_addr", 32'(bram_addr), 32'(e.addr));
        chk("bram_wdata", bram_wdata, e.wdata);
        chk("data_addr", 32'(data_addr), 32'(e.daddr));
        chk("perc_enable", 32'(perc_enable), 32'(e.pen));
        chk("result", 32'(result), 32'(e.res));
        chk("result_fire", 32'(result_fire), 32'(e.rf));
    endtask

    task automatic step(input logic st);
        ent_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0 && st) push_run();
        e = (q.size() > 0) ? q.pop_front() : idle_ent();
        start     = st;
        perc_y    = e.py;
        perc_fire = e.pf;
        out_addr  = e.oa;
        @(negedge clk);
        cmp_ent(e);
        $display("cyc=%0d start=%0b busy=%0b done=%0b en=%0b we=%0b addr=%0d daddr=%0d pen=%0b result=%h",
                 cyc, st, busy, done, bram_en, bram_we, bram_addr, data_addr, perc_enable, result);
        cyc++;
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        start     = 1'b0;
        perc_y    = 16'h0;
        perc_fire = 1'b0;
        out_addr  = 9'h0;
        q.delete();
        m_res  = 16'h0;
        m_fire = 1'b0;
        #1;
        cmp_ent(idle_ent());
        @(negedge clk);
        cmp_ent(idle_ent());
        $display("cyc=%0d reset asserted mid-run", cyc);
        cyc++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cmp_ent(idle_ent());
        cyc++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; perc_y = 16'h0; perc_fire = 1'b0; out_addr = 9'h0;
        m_res = 16'h0; m_fire = 1'b0;
        nx_base = 16'h1234; nx_vary = 1'b0; nx_oa = 9'd8;
        repeat (2) @(negedge clk);
        cmp_ent(idle_ent());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);

        // Single pulse run with constant perceptron output.
        step(1'b1);
        for (int i = 1; i <= DONE_C + 2; i++) step(1'b0);

        // Re-pulses of start while busy are ignored.
        nx_base = 16'hA000; nx_vary = 1'b1; nx_oa = 9'h155;
        step(1'b1);
        for (int i = 1; i <= DONE_C + 3; i++) step((i == 5) || (i == 12));

        // Reset in the middle of a run, then a clean restart.
        nx_base = 16'h5A5A; nx_vary = 1'b1; nx_oa = 9'h0F0;
        step(1'b1);
        for (int i = 1; i <= 9; i++) step(1'b0);
        reset_mid();
        step(1'b0);
        nx_base = 16'h0F00; nx_vary = 1'b1; nx_oa = 9'h1FF;
        step(1'b1);
        for (int i = 1; i <= DONE_C + 1; i++) step(1'b0);

        // Start held high: back-to-back runs.
        nx_base = 16'hC3C3; nx_vary = 1'b1; nx_oa = 9'h0AA;
        for (int i = 0; i < 3 * (DONE_C + 1) + 2; i++) step(1'b1);
        for (int i = 0; i < DONE_C + 3; i++) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
